// File: rtl/decryption_frame_router.sv
// Ingress router for the decryption engines: buffers {sel, char} entries in a FIFO and
// forwards one token-terminated message at a time to the selected engine.
module decryption_frame_router #(
   parameter int unsigned         D_WIDTH                = 8,
   parameter int unsigned         FIFO_DEPTH             = 8,
   parameter int unsigned         MAX_NOF_CHARS          = 50,
   parameter logic [D_WIDTH-1:0]  START_DECRYPTION_TOKEN = 8'hFA,
   parameter int unsigned         BUSY_TIMEOUT           = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] data_i,
   input  logic               valid_i,
   input  logic [1:0]         sel_i,
   output logic               ready_o,
   output logic [D_WIDTH-1:0] data_o,
   output logic [2:0]         valid_o,
   input  logic [2:0]         busy_i,
   output logic               err_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(MAX_NOF_CHARS + 1);
   localparam int unsigned WW = $clog2(BUSY_TIMEOUT + 1);
   localparam int unsigned EW = D_WIDTH + 2;

   typedef enum logic [1:0] {S_IDLE, S_FWD, S_WAIT_BUSY, S_WAIT_DONE} state_t;

   logic [EW-1:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW:0]        count_q, count_d;
   logic               first_q, first_d;
   logic [1:0]         last_sel_q, last_sel_d;

   state_t             state_q, state_d;
   logic [1:0]         cur_sel_q, cur_sel_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WW-1:0]      wcnt_q, wcnt_d;
   logic               ovf_q, ovf_d;
   logic [D_WIDTH-1:0] data_q, data_d;
   logic [2:0]         valid_q, valid_d;
   logic               err_q, err_d;

   logic               full, empty, push, pop;
   logic [1:0]         entry_sel;
   logic [EW-1:0]      head;
   logic [1:0]         head_sel;
   logic [D_WIDTH-1:0] head_data;
   logic               head_is_token;
   logic [3:0]         busy_ext;
   logic [WW-1:0]      wcnt_inc;
   logic [2:0]         sel_onehot;

   assign full          = (count_q == (PW+1)'(FIFO_DEPTH));
   assign empty         = (count_q == '0);
   assign ready_o       = !full;
   assign push          = valid_i && !full;
   assign entry_sel     = first_q ? sel_i : last_sel_q;
   assign head          = mem_q[rd_ptr_q];
   assign head_sel      = head[EW-1 -: 2];
   assign head_data     = head[D_WIDTH-1:0];
   assign head_is_token = (head_data == START_DECRYPTION_TOKEN);
   // Padding bit 3 lets a cur_sel of 3 index safely; that state never waits on busy.
   assign busy_ext      = {1'b0, busy_i};
   assign wcnt_inc      = wcnt_q + WW'(1);
   assign sel_onehot    = 3'b001 << cur_sel_q;

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign err_o   = err_q;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      first_d    = first_q;
      last_sel_d = last_sel_q;
      state_d    = state_q;
      cur_sel_d  = cur_sel_q;
      cnt_d      = cnt_q;
      wcnt_d     = wcnt_q;
      ovf_d      = ovf_q;
      data_d     = '0;
      valid_d    = '0;
      err_d      = 1'b0;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               cur_sel_d = head_sel;
               cnt_d     = '0;
               ovf_d     = 1'b0;
               state_d   = S_FWD;
            end
         end
         S_FWD: begin
            if (!empty) begin
               pop = 1'b1;
               if (cur_sel_q == 2'd3) begin
                  if (head_is_token) begin
                     err_d   = 1'b1;
                     state_d = S_IDLE;
                  end
               end else if (head_is_token) begin
                  data_d  = head_data;
                  valid_d = sel_onehot;
                  wcnt_d  = '0;
                  state_d = S_WAIT_BUSY;
               end else if (cnt_q != CW'(MAX_NOF_CHARS)) begin
                  data_d  = head_data;
                  valid_d = sel_onehot;
                  cnt_d   = cnt_q + CW'(1);
               end else if (!ovf_q) begin
                  err_d = 1'b1;
                  ovf_d = 1'b1;
               end
            end
         end
         S_WAIT_BUSY: begin
            if (busy_ext[cur_sel_q]) begin
               state_d = S_WAIT_DONE;
            end else begin
               wcnt_d = wcnt_inc;
               if (wcnt_inc == WW'(BUSY_TIMEOUT)) state_d = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (!busy_ext[cur_sel_q]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         wr_ptr_d   = wr_ptr_q + PW'(1);
         first_d    = (data_i == START_DECRYPTION_TOKEN);
         last_sel_d = entry_sel;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + (PW+1)'(1);
      else if (!push && pop) count_d = count_q - (PW+1)'(1);
   end

   // NOTE: FIFO storage has no reset; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {entry_sel, data_i};
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         first_q    <= 1'b1;
         last_sel_q <= '0;
         state_q    <= S_IDLE;
         cur_sel_q  <= '0;
         cnt_q      <= '0;
         wcnt_q     <= '0;
         ovf_q      <= 1'b0;
         data_q     <= '0;
         valid_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         first_q    <= first_d;
         last_sel_q <= last_sel_d;
         state_q    <= state_d;
         cur_sel_q  <= cur_sel_d;
         cnt_q      <= cnt_d;
         wcnt_q     <= wcnt_d;
         ovf_q      <= ovf_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_decryption_frame_router.sv
// Scoreboard bench for decryption_frame_router: directed messages, expected outputs queued
// by the stimulus and popped by an independent negedge monitor.
module tb_decryption_frame_router;

   localparam logic [7:0] TOK = 8'hFA;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_i;
   logic       valid_i;
   logic [1:0] sel_i;
   logic       ready_o;
   logic [7:0] data_o;
   logic [2:0] valid_o;
   logic [2:0] busy_i;
   logic       err_o;

   decryption_frame_router dut (
      .clk     (clk),
      .rst     (rst),
      .data_i  (data_i),
      .valid_i (valid_i),
      .sel_i   (sel_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .busy_i  (busy_i),
      .err_o   (err_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] v;
      logic [7:0] d;
      int         gap;   // required cycles since previous output, 0 = any
   } exp_t;

   exp_t exp_q[$];
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   err_seen = 0;
   int   last_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic expect_out(input logic [2:0] v, input logic [7:0] d, input int gap);
      exp_t e;
      e.v = v; e.d = d; e.gap = gap;
      exp_q.push_back(e);
   endtask

   // Monitor: compares every driven character against the scoreboard head.
   always @(negedge clk) begin
      if (!rst) begin
         if (err_o) err_seen++;
         if (valid_o != 3'b000) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_out: got valid 0x%0h data 0x%0h, required no output (cycle %0d)",
                        valid_o, data_o, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("out_valid_data", {21'd0, valid_o, data_o}, {21'd0, e.v, e.d});
               if (e.gap != 0) check("out_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
         end else begin
            check("idle_data_zero", {24'd0, data_o}, 32'd0);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the char was accepted.
   task automatic push(input logic [1:0] s, input logic [7:0] d);
      int guard;
      guard = 0;
      valid_i = 1'b1; sel_i = s; data_i = d;
      while (!ready_o && guard < 500) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!ready_o) check("push_ready_timeout", {31'd0, ready_o}, 32'd1);
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_out(input logic [2:0] v, input logic [7:0] d, input int budget);
      int  b;
      bit  seen;
      b = 0; seen = 0;
      while (!seen && b < budget) begin
         @(negedge clk);
         if (valid_o == v && data_o == d) seen = 1;
         b++;
      end
      check("wait_out_seen", {31'd0, seen}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(input int budget);
      int b;
      b = 0;
      while (exp_q.size() != 0 && b < budget) begin @(posedge clk); #1; b++; end
      check("scoreboard_drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int t_drop;
      int b;
      bit seen;

      rst = 1'b1; valid_i = 1'b0; data_i = '0; sel_i = '0; busy_i = '0;
      #2;
      check("reset_ready", {31'd0, ready_o}, 32'd1);
      check("reset_valid", {29'd0, valid_o}, 32'd0);
      check("reset_data", {24'd0, data_o}, 32'd0);
      check("reset_err", {31'd0, err_o}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Message to engine 2; later chars carry sel 0 to show sel is taken from the first.
      expect_out(3'b100, 8'h41, 0);
      expect_out(3'b100, 8'h42, 1);
      expect_out(3'b100, 8'h43, 1);
      expect_out(3'b100, TOK, 1);
      push(2'd2, 8'h41); push(2'd0, 8'h42); push(2'd0, 8'h43); push(2'd0, TOK);
      wait_out(3'b100, TOK, 20);
      busy_i[2] = 1'b1;
      tick(1);
      // Next message buffered during WAIT_DONE must not appear until busy falls.
      expect_out(3'b001, 8'h61, 0);
      expect_out(3'b001, TOK, 1);
      push(2'd0, 8'h61); push(2'd3, TOK);
      repeat (3) begin
         @(negedge clk);
         check("quiet_while_busy", {29'd0, valid_o}, 32'd0);
         @(posedge clk); #1;
      end
      busy_i[2] = 1'b0;
      t_drop = cyc;
      b = 0; seen = 0;
      while (!seen && b < 20) begin
         @(negedge clk);
         if (valid_o != 3'b000) seen = 1;
         else b++;
      end
      check("resume_latency", cyc, t_drop + 3);
      @(posedge clk); #1;
      wait_drain(20);
      tick(8);

      // FIFO fills while engine 1 holds busy; the 9th char waits at the source.
      expect_out(3'b010, 8'h70, 0);
      expect_out(3'b010, TOK, 1);
      push(2'd1, 8'h70); push(2'd1, TOK);
      wait_out(3'b010, TOK, 20);
      busy_i[1] = 1'b1;
      tick(1);
      for (int i = 0; i < 8; i++) expect_out(3'b010, 8'h80 + 8'(i), (i == 0) ? 0 : 1);
      expect_out(3'b010, TOK, 1);
      for (int i = 0; i < 8; i++) push(2'd1, 8'h80 + 8'(i));
      check("fifo_full_ready", {31'd0, ready_o}, 32'd0);
      valid_i = 1'b1; data_i = TOK; sel_i = 2'd1;
      repeat (3) begin
         tick(1);
         check("full_hold_ready", {31'd0, ready_o}, 32'd0);
      end
      busy_i[1] = 1'b0;
      push(2'd1, TOK);
      wait_drain(40);
      tick(8);

      // Invalid selector: everything dropped, one error pulse on the token.
      e0 = err_seen;
      push(2'd3, 8'h10); push(2'd0, 8'h11); push(2'd0, TOK);
      tick(6);
      check("sel3_err_pulses", err_seen - e0, 32'd1);
      tick(4);

      // Overflow: 52 chars, only 50 forwarded, then the token 3 cycles after char 50.
      e0 = err_seen;
      for (int i = 0; i < 50; i++) expect_out(3'b010, 8'(i + 1), (i == 0) ? 0 : 1);
      expect_out(3'b010, TOK, 3);
      push(2'd1, 8'h01);
      for (int i = 1; i < 52; i++) push(2'd0, 8'(i + 1));
      push(2'd0, TOK);
      wait_drain(20);
      check("overflow_err_pulses", err_seen - e0, 32'd1);
      tick(8);

      // Engine never raises busy: next message starts BUSY_TIMEOUT+2 cycles after the token.
      expect_out(3'b100, 8'hC1, 0);
      expect_out(3'b100, TOK, 1);
      expect_out(3'b001, 8'hD1, 6);
      expect_out(3'b001, TOK, 1);
      push(2'd2, 8'hC1); push(2'd2, TOK); push(2'd0, 8'hD1); push(2'd2, TOK);
      wait_drain(40);
      tick(8);

      // Asynchronous reset in the middle of forwarding.
      for (int i = 0; i < 5; i++) expect_out(3'b001, 8'hA1 + 8'(i), (i == 0) ? 0 : 1);
      for (int i = 0; i < 5; i++) push(2'd0, 8'hA1 + 8'(i));
      check("fwd_before_reset", {21'd0, valid_o, data_o}, {21'd0, 3'b001, 8'hA3});
      #1;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("async_rst_valid", {29'd0, valid_o}, 32'd0);
      check("async_rst_data", {24'd0, data_o}, 32'd0);
      check("async_rst_err", {31'd0, err_o}, 32'd0);
      check("async_rst_ready", {31'd0, ready_o}, 32'd1);
      valid_i = 1'b1; data_i = 8'h55; sel_i = 2'd0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_ignores_input", {31'd0, ready_o}, 32'd1);
      valid_i = 1'b0;
      rst = 1'b0;
      tick(8);
      check("post_reset_ready", {31'd0, ready_o}, 32'd1);
      check("post_reset_empty", {29'd0, valid_o}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
